// File: rtl/vga_scan_timing.sv
// Free-running VGA raster timing generator: scan position, syncs and line/frame strobes.
// Optional VGA_FRAME_COUNT_EN adds an 8-bit frame counter output (frame_cnt).
module vga_scan_timing #(
  parameter int unsigned CLK_DIV   = 1,
  parameter int unsigned H_VISIBLE = 800,
  parameter int unsigned H_FRONT   = 56,
  parameter int unsigned H_SYNC    = 120,
  parameter int unsigned H_BACK    = 64,
  parameter int unsigned V_VISIBLE = 600,
  parameter int unsigned V_FRONT   = 37,
  parameter int unsigned V_SYNC    = 6,
  parameter int unsigned V_BACK    = 23,
  parameter bit          SYNC_POL  = 1'b1
) (
  input  logic        sysclk,
  input  logic        rst,
  output logic [21:0] display_addr,
  output logic        hsync,
  output logic        vsync,
  output logic        pixel_tick,
  output logic        line_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [7:0]  frame_cnt
`endif
);

  localparam int unsigned PW      = 4;
  localparam int unsigned XW      = 10;
  localparam int unsigned CW      = 11;
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_BEG  = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END  = H_VISIBLE + H_FRONT + H_SYNC;
  localparam int unsigned VS_BEG  = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END  = V_VISIBLE + V_FRONT + V_SYNC;

  logic [PW-1:0] r_presc;
  logic [XW-1:0] r_x;
  logic [XW-1:0] r_y;
  logic [21:0]   r_display_addr;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_pixel_tick;
  logic          r_line_start;

  logic          w_tick;
  logic          w_x_wrap;
  logic          w_y_wrap;
  logic [XW-1:0] w_nx;
  logic [XW-1:0] w_ny;
  logic [CW-1:0] w_nx_c;
  logic [CW-1:0] w_ny_c;
  logic          w_active;
  logic          w_frame_start;
  logic          w_hs_on;
  logic          w_vs_on;

  // Next scan position and its decode; only committed on a tick.
  always_comb begin
    w_tick        = (r_presc == PW'(CLK_DIV - 1));
    w_x_wrap      = (r_x == XW'(H_TOTAL - 1));
    w_y_wrap      = (r_y == XW'(V_TOTAL - 1));
    w_nx          = w_x_wrap ? '0 : r_x + XW'(1);
    w_ny          = r_y;
    if (w_x_wrap) w_ny = w_y_wrap ? '0 : r_y + XW'(1);
    w_nx_c        = {1'b0, w_nx};
    w_ny_c        = {1'b0, w_ny};
    w_active      = (w_nx_c < CW'(H_VISIBLE)) && (w_ny_c < CW'(V_VISIBLE));
    w_frame_start = (w_nx == '0) && (w_ny == '0);
    w_hs_on       = (w_nx_c >= CW'(HS_BEG)) && (w_nx_c < CW'(HS_END));
    w_vs_on       = (w_ny_c >= CW'(VS_BEG)) && (w_ny_c < CW'(VS_END));
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
    end
  end

  // Counters and registered outputs update together so flags never lag the position.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_x            <= XW'(H_TOTAL - 1);
      r_y            <= XW'(V_TOTAL - 1);
      r_display_addr <= '0;
      r_hsync        <= ~SYNC_POL;
      r_vsync        <= ~SYNC_POL;
      r_pixel_tick   <= 1'b0;
      r_line_start   <= 1'b0;
    end else begin
      r_pixel_tick          <= w_tick;
      r_line_start          <= w_tick && (w_nx == '0);
      r_display_addr[20]    <= w_tick && w_frame_start;
      if (w_tick) begin
        r_x                   <= w_nx;
        r_y                   <= w_ny;
        r_display_addr[21]    <= w_active;
        r_display_addr[19:10] <= w_nx;
        r_display_addr[9:0]   <= w_ny;
        r_hsync               <= w_hs_on ? SYNC_POL : ~SYNC_POL;
        r_vsync               <= w_vs_on ? SYNC_POL : ~SYNC_POL;
      end
    end
  end

  assign display_addr = r_display_addr;
  assign hsync        = r_hsync;
  assign vsync        = r_vsync;
  assign pixel_tick   = r_pixel_tick;
  assign line_start   = r_line_start;

`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] r_frame_cnt;

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_frame_cnt <= '0;
    end else if (w_tick && w_frame_start) begin
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_scan_timing.sv
// Self-checking bench for vga_scan_timing: three instances (div 1, div 3, negative syncs)
// compared every cycle against a position-from-edge-count model, plus literal spot checks.
module tb_vga_scan_timing;

  localparam int HV = 8, HF = 2, HS = 2, HB = 4;
  localparam int VV = 4, VF = 1, VS = 1, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;

  typedef struct packed {
    logic [21:0] addr;
    logic        hs;
    logic        vs;
    logic        pt;
    logic        ls;
    logic [7:0]  fc;
  } exp_t;

  logic sysclk = 1'b0;
  logic rst    = 1'b1;
  int   k      = 0;
  int   n_cmp  = 0;
  int   n_err  = 0;

  logic [21:0] addr0, addr1, addr2;
  logic hs0, hs1, hs2, vs0, vs1, vs2, pt0, pt1, pt2, ls0, ls1, ls2;
  logic [7:0] fc0, fc1, fc2;

  always #5 sysclk = ~sysclk;

  // Edges since reset release; the model derives everything from this count.
  always @(posedge sysclk or posedge rst) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  vga_scan_timing #(.CLK_DIV(1), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(1'b1)) u_dut0 (
    .sysclk(sysclk), .rst(rst), .display_addr(addr0), .hsync(hs0), .vsync(vs0),
    .pixel_tick(pt0), .line_start(ls0)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_cnt(fc0)
`endif
  );

  vga_scan_timing #(.CLK_DIV(3), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(1'b1)) u_dut1 (
    .sysclk(sysclk), .rst(rst), .display_addr(addr1), .hsync(hs1), .vsync(vs1),
    .pixel_tick(pt1), .line_start(ls1)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_cnt(fc1)
`endif
  );

  vga_scan_timing #(.CLK_DIV(2), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(1'b0)) u_dut2 (
    .sysclk(sysclk), .rst(rst), .display_addr(addr2), .hsync(hs2), .vsync(vs2),
    .pixel_tick(pt2), .line_start(ls2)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_cnt(fc2)
`endif
  );

`ifndef VGA_FRAME_COUNT_EN
  assign fc0 = 8'd0;
  assign fc1 = 8'd0;
  assign fc2 = 8'd0;
`endif

  // After k edges there have been k/div ticks; tick t lands on raster index t-1.
  function automatic exp_t model(input int kk, input int div, input bit pol);
    exp_t e;
    int t, p, x, y;
    bit act, fs;
    e      = '0;
    t      = kk / div;
    e.pt   = (kk > 0) && (kk % div == 0);
    e.hs   = ~pol;
    e.vs   = ~pol;
    if (t == 0) return e;
    p      = (t - 1) % (HT * VT);
    x      = p % HT;
    y      = p / HT;
    act    = (x < HV) && (y < VV);
    fs     = e.pt && (p == 0);
    e.addr = {act, fs, 10'(x), 10'(y)};
    e.hs   = (x >= HV + HF && x < HV + HF + HS) ? pol : ~pol;
    e.vs   = (y >= VV + VF && y < VV + VF + VS) ? pol : ~pol;
    e.ls   = e.pt && (x == 0);
    e.fc   = 8'(((t - 1) / (HT * VT) + 1) % 256);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at k=%0d: got %0h, expected %0h", nm, k, act, exp);
    end
  endtask

  task automatic chk_dut(input string nm, input logic [21:0] a, input logic h, input logic v,
                         input logic p, input logic l, input logic [7:0] f, input exp_t e);
    chk({nm, ".addr"}, 32'(a), 32'(e.addr));
    chk({nm, ".hsync"}, 32'(h), 32'(e.hs));
    chk({nm, ".vsync"}, 32'(v), 32'(e.vs));
    chk({nm, ".pixel_tick"}, 32'(p), 32'(e.pt));
    chk({nm, ".line_start"}, 32'(l), 32'(e.ls));
`ifdef VGA_FRAME_COUNT_EN
    chk({nm, ".frame_cnt"}, 32'(f), 32'(e.fc));
`else
    if (f !== 8'd0) chk({nm, ".frame_cnt_tie"}, 32'(f), 32'd0);
`endif
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge sysclk) begin
    chk_dut("d0", addr0, hs0, vs0, pt0, ls0, fc0, model(k, 1, 1'b1));
    chk_dut("d1", addr1, hs1, vs1, pt1, ls1, fc1, model(k, 3, 1'b1));
    chk_dut("d2", addr2, hs2, vs2, pt2, ls2, fc2, model(k, 2, 1'b0));
  end

  task automatic wait_k(input int target);
    int n;
    n = 0;
    while (k != target && n < 40000) begin
      @(negedge sysclk);
      n++;
    end
    if (k != target) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_k: got k=%0d, expected %0d", k, target);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge sysclk);
    #2 rst = 1'b1;
    repeat (cycles) @(negedge sysclk);
  endtask

  task automatic release_rst();
    @(negedge sysclk);
    #2 rst = 1'b0;
  endtask

  initial begin
    exp_t m;
    // Pin the model itself with hand-derived values.
    m = model(11, 1, 1'b1);
    chk("model.k11_addr", 32'(m.addr), 32'h002800);
    chk("model.k11_hs", 32'(m.hs), 32'd1);
    m = model(129, 1, 1'b1);
    chk("model.k129_addr", 32'(m.addr), 32'h300000);
    chk("model.k129_fc", 32'(m.fc), 32'd2);

    repeat (3) @(negedge sysclk);
    chk("rst.addr0", 32'(addr0), 32'd0);
    chk("rst.hs2_idle_high", 32'(hs2), 32'd1);
    release_rst();

    wait_k(1);
    chk("first.addr0", 32'(addr0), 32'h300000);
    chk("first.ls0", 32'(ls0), 32'd1);
    chk("first.addr1_no_tick", 32'(addr1), 32'd0);
    wait_k(3);
    chk("div3.addr1_tick", 32'(addr1), 32'h300000);
    chk("div3.pt1", 32'(pt1), 32'd1);
    wait_k(4);
    chk("div3.addr1_hold", 32'(addr1), 32'h200000);
    chk("div3.ls1_drop", 32'(ls1), 32'd0);
    wait_k(11);
    chk("hs0.x10", 32'(hs0), 32'd1);
    chk("addr0.x10", 32'(addr0), 32'h002800);
    wait_k(13);
    chk("hs0.x12", 32'(hs0), 32'd0);
    wait_k(54);
    chk("addr0.x5y3", 32'(addr0), 32'h201403);

    do_reset(2);
    chk("midrst.addr0", 32'(addr0), 32'd0);
    chk("midrst.hs0", 32'(hs0), 32'd0);
    chk("midrst.vs0", 32'(vs0), 32'd0);
    chk("midrst.vs2", 32'(vs2), 32'd1);
    release_rst();
    wait_k(1);
    chk("postrst.addr0", 32'(addr0), 32'h300000);
    wait_k(81);
    chk("vs0.y5", 32'(vs0), 32'd1);
    chk("addr0.x0y5", 32'(addr0), 32'h000005);
    wait_k(97);
    chk("vs0.y6", 32'(vs0), 32'd0);
    wait_k(129);
    chk("frame2.addr0", 32'(addr0), 32'h300000);
`ifdef VGA_FRAME_COUNT_EN
    chk("frame2.fc0", 32'(fc0), 32'd2);
`endif

    // Randomised run lengths and reset pulses.
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(20, 400)) @(negedge sysclk);
      do_reset($urandom_range(1, 3));
      release_rst();
    end

    // Long run to cover the frame counter wrap.
    do_reset(1);
    release_rst();
    wait_k(32513);
`ifdef VGA_FRAME_COUNT_EN
    chk("fc0.255", 32'(fc0), 32'd255);
`endif
    wait_k(32641);
    chk("wrap.addr0", 32'(addr0), 32'h300000);
`ifdef VGA_FRAME_COUNT_EN
    chk("fc0.wrap0", 32'(fc0), 32'd0);
`endif
    @(negedge sysclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
